// File: rtl/bg_draw_pkg.sv
// Shared types and constants for the background draw generator.
package bg_draw_pkg;

    typedef enum logic [1:0] {
        BG_PLAIN    = 2'd0,
        BG_BRACKETS = 2'd1,
        BG_MATRIX   = 2'd2,
        BG_BLINK    = 2'd3
    } bg_mode_t;

    typedef logic [7:0] rgb332_t;

    localparam rgb332_t RGB_BLACK = 8'h00;
    localparam rgb332_t RGB_WHITE = 8'hFF;

endpackage

// File: rtl/bg_frame_sync.sv
// Frame synchroniser: start-of-frame detection, pending/active mode and blink phase.
module bg_frame_sync
    import bg_draw_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [1:0]  mode_in,
    input  logic        mode_load,
    output bg_mode_t    eff_mode,
    output logic        blink_phase
);

    logic     at_origin;
    logic     sof;
    logic     sof_d;
    bg_mode_t pending_q;
    bg_mode_t active_q;
    bg_mode_t next_mode;
    logic [7:0] frame_cnt_q;

    // Origin detection and mode selection for the current pixel
    always_comb begin
        at_origin = (pixelX == 11'd0) && (pixelY == 11'd0);
        sof       = at_origin && !sof_d;
        // A load coincident with sof wins over the stored pending mode
        next_mode = mode_load ? bg_mode_t'(mode_in) : pending_q;
        eff_mode  = sof ? next_mode : active_q;
    end

    // Frame-synchronous state: mode registers and blink counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sof_d       <= 1'b0;
            pending_q   <= BG_PLAIN;
            active_q    <= BG_PLAIN;
            frame_cnt_q <= 8'd0;
            blink_phase <= 1'b0;
        end else begin
            sof_d <= at_origin;
            if (mode_load) begin
                pending_q <= bg_mode_t'(mode_in);
            end
            if (sof) begin
                active_q <= next_mode;
                if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                    frame_cnt_q <= 8'd0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/back_ground_draw_gen.sv
// Background generator: classifies each pixel and registers the RGB332 colour.
module back_ground_draw_gen
    import bg_draw_pkg::*;
#(
    parameter int unsigned X_FRAME_SIZE   = 635,
    parameter int unsigned Y_FRAME_SIZE   = 475,
    parameter int unsigned BRACKET_OFFSET = 30,
    parameter int unsigned MATRIX_LEFT_X  = 100,
    parameter int unsigned MATRIX_TOP_Y   = 100,
    parameter int unsigned CELL_W_LOG2    = 4,
    parameter int unsigned CELL_H_LOG2    = 1,
    parameter int unsigned BLINK_FRAMES   = 30,
    parameter rgb332_t     BG_COLOR       = RGB_WHITE,
    parameter rgb332_t     BRACKET_COLOR  = RGB_WHITE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [1:0]  mode_in,
    input  logic        mode_load,
    output logic [7:0]  BG_RGB,
    output logic        bordersDrawReq,
    output logic        blink_phase
);

    localparam logic [10:0] BrLeft   = 11'(BRACKET_OFFSET);
    localparam logic [10:0] BrTop    = 11'(BRACKET_OFFSET);
    localparam logic [10:0] BrRight  = 11'(X_FRAME_SIZE - BRACKET_OFFSET);
    localparam logic [10:0] BrBottom = 11'(Y_FRAME_SIZE - BRACKET_OFFSET);
    localparam logic [10:0] MxLeft   = 11'(MATRIX_LEFT_X);
    localparam logic [10:0] MxTop    = 11'(MATRIX_TOP_Y);
    localparam logic [10:0] MxRight  = 11'(MATRIX_LEFT_X + (16 << CELL_W_LOG2));
    localparam logic [10:0] MxBottom = 11'(MATRIX_TOP_Y + (16 << CELL_H_LOG2));

    bg_mode_t    eff_mode;
    logic        bp;
    logic        mr;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [3:0]  col;
    logic [3:0]  row;
    rgb332_t     matrix_rgb;
    rgb332_t     pix_rgb;
    logic        sel_bracket;

    bg_frame_sync #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_frame_sync (
        .clk        (clk),
        .reset      (reset),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .mode_in    (mode_in),
        .mode_load  (mode_load),
        .eff_mode   (eff_mode),
        .blink_phase(blink_phase)
    );

    // Pixel classification: bracket lines and colour-matrix cell
    always_comb begin
        bp = (pixelX == BrLeft) || (pixelY == BrTop) ||
             (pixelX == BrRight) || (pixelY == BrBottom);
        mr = (pixelX >= MxLeft) && (pixelX < MxRight) &&
             (pixelY >= MxTop) && (pixelY < MxBottom);
        // Offsets forced to zero outside the region so no wrapped value leaks out
        dx = mr ? (pixelX - MxLeft) : 11'd0;
        dy = mr ? (pixelY - MxTop) : 11'd0;
        col = 4'(dx >> CELL_W_LOG2);
        row = 4'(dy >> CELL_H_LOG2);
        matrix_rgb = {row, col};
    end

    // Per-mode colour priority
    always_comb begin
        sel_bracket = 1'b0;
        pix_rgb     = BG_COLOR;
        case (eff_mode)
            BG_PLAIN: begin
                sel_bracket = 1'b0;
            end
            BG_BRACKETS: begin
                sel_bracket = bp;
            end
            BG_MATRIX: begin
                sel_bracket = bp;
                if (!bp && mr) begin
                    pix_rgb = matrix_rgb;
                end
            end
            BG_BLINK: begin
                sel_bracket = bp && !blink_phase;
            end
            default: begin
                sel_bracket = 1'b0;
            end
        endcase
        if (sel_bracket) begin
            pix_rgb = BRACKET_COLOR;
        end
    end

    // One-cycle output register
    always_ff @(posedge clk) begin
        if (reset) begin
            BG_RGB         <= RGB_BLACK;
            bordersDrawReq <= 1'b0;
        end else begin
            BG_RGB         <= pix_rgb;
            bordersDrawReq <= sel_bracket;
        end
    end

endmodule

// File: tb/tb_back_ground_draw_gen.sv
// Self-checking bench: directed scenarios plus random pixels against a frame-level model.
module tb_back_ground_draw_gen;

    logic        clk;
    logic        reset;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [1:0]  mode_in;
    logic        mode_load;
    logic [7:0]  BG_RGB;
    logic        bordersDrawReq;
    logic        blink_phase;

    int checks;
    int errors;

    // Model state: frame-level view
    int m_pend;
    int m_act;
    bit m_prev_origin;
    int m_sofs;

    back_ground_draw_gen dut (
        .clk           (clk),
        .reset         (reset),
        .pixelX        (pixelX),
        .pixelY        (pixelY),
        .mode_in       (mode_in),
        .mode_load     (mode_load),
        .BG_RGB        (BG_RGB),
        .bordersDrawReq(bordersDrawReq),
        .blink_phase   (blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {req, rgb} for a pixel in a given mode and blink phase
    function automatic logic [8:0] model_pix(input int x, input int y, input int mode,
                                             input int phase);
        bit on_bracket;
        bit in_matrix;
        on_bracket = (x == 30) || (y == 30) || (x == 635 - 30) || (y == 475 - 30);
        in_matrix  = (x >= 100) && (x < 100 + 256) && (y >= 100) && (y < 100 + 32);
        case (mode)
            1: return on_bracket ? 9'h1FF : 9'h0FF;
            2: begin
                if (on_bracket) return 9'h1FF;
                if (in_matrix) return {1'b0, 8'(((y - 100) / 2) * 16 + (x - 100) / 16)};
                return 9'h0FF;
            end
            3: return (on_bracket && phase == 0) ? 9'h1FF : 9'h0FF;
            default: return 9'h0FF;
        endcase
    endfunction

    task automatic model_reset();
        m_pend        = 0;
        m_act         = 0;
        m_prev_origin = 0;
        m_sofs        = 0;
    endtask

    task automatic do_reset(input int n, input int x, input int y);
        reset     = 1'b1;
        pixelX    = 11'(x);
        pixelY    = 11'(y);
        mode_load = 1'b0;
        mode_in   = 2'd0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_rgb", 32'(BG_RGB), 32'h00);
            check_eq("rst_req", 32'(bordersDrawReq), 32'h0);
            check_eq("rst_phase", 32'(blink_phase), 32'h0);
        end
        model_reset();
        reset = 1'b0;
    endtask

    // One pixel clock: drive, predict, clock, compare
    task automatic step(input int x, input int y, input bit ml, input int mi);
        bit          origin;
        bit          sof;
        int          eff;
        int          phase_now;
        logic [8:0]  exp;
        reset     = 1'b0;
        pixelX    = 11'(x);
        pixelY    = 11'(y);
        mode_load = ml;
        mode_in   = 2'(mi);
        origin    = (x == 0) && (y == 0);
        sof       = origin && !m_prev_origin;
        // Phase flips every BLINK_FRAMES frames and becomes visible one cycle after the sof
        phase_now = (m_sofs / 30) % 2;
        eff       = sof ? (ml ? mi : m_pend) : m_act;
        exp       = model_pix(x, y, eff, phase_now);
        if (sof) begin
            m_act = eff;
            m_sofs++;
        end
        if (ml) m_pend = mi;
        m_prev_origin = origin;
        @(posedge clk);
        #1;
        check_eq("rgb", 32'(BG_RGB), 32'(exp[7:0]));
        check_eq("req", 32'(bordersDrawReq), 32'(exp[8]));
        check_eq("phase", 32'(blink_phase), 32'((m_sofs / 30) % 2));
        mode_load = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        pixelX    = 11'd5;
        pixelY    = 11'd5;
        mode_in   = 2'd0;
        mode_load = 1'b0;
        model_reset();

        // Reset held then released
        do_reset(3, 5, 5);
        step(5, 5, 0, 0);
        check_eq("release_rgb", 32'(BG_RGB), 32'hFF);
        check_eq("release_req", 32'(bordersDrawReq), 32'h0);

        // Mid-frame load does not affect the current frame
        step(0, 0, 0, 0);
        step(10, 10, 1, 1);
        step(30, 200, 0, 0);
        check_eq("same_frame_req", 32'(bordersDrawReq), 32'h0);
        step(0, 0, 0, 0);
        step(30, 200, 0, 0);
        check_eq("next_frame_req", 32'(bordersDrawReq), 32'h1);
        check_eq("next_frame_rgb", 32'(BG_RGB), 32'hFF);

        // Matrix mode
        step(50, 50, 1, 2);
        step(0, 0, 0, 0);
        step(100 + 16 * 3 + 5, 100 + 2 * 10 + 1, 0, 0);
        check_eq("matrix_cell", 32'(BG_RGB), 32'hA3);
        step(356, 100, 0, 0);
        check_eq("matrix_xend", 32'(BG_RGB), 32'hFF);
        step(355, 131, 0, 0);
        check_eq("matrix_corner", 32'(BG_RGB), 32'hFF);

        // Load coincident with sof applies at once; not re-applied later
        step(200, 300, 1, 0);
        step(0, 0, 1, 2);
        step(110, 102, 0, 0);
        check_eq("coinc_matrix", 32'(BG_RGB), 32'h10);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(120, 104, 0, 0);
        check_eq("coinc_keep", 32'(BG_RGB), 32'h21);

        // Blink: 30 sofs toggle the phase, origin held 5 cycles counts once
        do_reset(1, 7, 7);
        step(5, 5, 0, 0);
        step(0, 0, 1, 3);
        for (int f = 2; f <= 30; f++) begin
            step(605, 240, 0, 0);
            step(0, 0, 0, 0);
            if (f == 10) begin
                for (int h = 0; h < 4; h++) step(0, 0, 0, 0);
            end
        end
        check_eq("blink_phase1", 32'(blink_phase), 32'h1);
        step(605, 240, 0, 0);
        check_eq("blink_req_off", 32'(bordersDrawReq), 32'h0);
        for (int f = 0; f < 30; f++) begin
            step(0, 0, 0, 0);
            step(605, 240, 0, 0);
        end
        check_eq("blink_phase0", 32'(blink_phase), 32'h0);
        check_eq("blink_req_on", 32'(bordersDrawReq), 32'h1);

        // Random pixels, loads and occasional resets
        for (int i = 0; i < 4000; i++) begin
            int x;
            int y;
            int r;
            r = $urandom_range(0, 99);
            x = $urandom_range(0, 639);
            y = $urandom_range(0, 479);
            if (r < 8) begin
                x = 0;
                y = 0;
            end else if (r < 20) begin
                x = ($urandom_range(0, 1) == 0) ? 30 : 605;
            end else if (r < 40) begin
                x = $urandom_range(95, 360);
                y = $urandom_range(95, 135);
            end
            if (r == 99 && $urandom_range(0, 3) == 0) begin
                do_reset(1, x, y);
            end else begin
                step(x, y, ($urandom_range(0, 29) == 0), $urandom_range(0, 3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
